// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one single-port frame-buffer SRAM between a real-time
// VGA pixel-fetch port (always wins) and a host write port (fills the gaps).
// Inserts read->write bus turnaround and returns read data with fixed latency.
// Optional feature macro: ARB_STATS_EN adds saturating read / host-wait counters.
module fb_mem_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 24,
    parameter int RD_LAT   = 1,
    parameter int TURN_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_valid,
    output logic [DATA_W-1:0] o_vga_data,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_re,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       o_stat_vga_reads,
    output logic [15:0]       o_stat_host_wait
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_TURN, S_WRITE} state_t;

    localparam logic [1:0] TURN_LD = 2'(TURN_CYC);

    state_t              r_state;
    logic [1:0]          r_turn_cnt;
    logic                r_mem_re;
    logic                r_mem_we;
    logic                r_wr_ack;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [RD_LAT:0]     r_vld_pipe;
    logic                r_vga_valid;
    logic [DATA_W-1:0]   r_vga_data;
    logic                w_turn_busy;

    // The turn counter is reloaded on every read and counts idle cycles down,
    // so a write is held off until TURN_CYC idle cycles follow the last read,
    // whether the path out of READ goes through TURN or through IDLE.
    assign w_turn_busy = (r_state == S_READ) || (r_turn_cnt != 2'd0);

    // Arbitration FSM with registered SRAM strobes, address, data and ack
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_turn_cnt  <= 2'd0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_wr_ack <= 1'b0;
            if (i_vga_req) begin
                r_state    <= S_READ;
                r_turn_cnt <= TURN_LD;
                r_mem_re   <= 1'b1;
                r_mem_addr <= i_vga_addr;
            end else begin
                if (r_turn_cnt != 2'd0)
                    r_turn_cnt <= r_turn_cnt - 2'd1;
                if (i_wr_req && !w_turn_busy) begin
                    r_state     <= S_WRITE;
                    r_mem_we    <= 1'b1;
                    r_wr_ack    <= 1'b1;
                    r_mem_addr  <= i_wr_addr;
                    r_mem_wdata <= i_wr_data;
                end else if (i_wr_req) begin
                    r_state <= S_TURN;
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // Read-return tagging: bit 0 mirrors mem_re, bit RD_LAT marks the cycle
    // in which mem_rdata is valid and gets captured for the VGA side
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe  <= '0;
            r_vga_valid <= 1'b0;
            r_vga_data  <= '0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[RD_LAT-1:0], i_vga_req};
            r_vga_valid <= r_vld_pipe[RD_LAT];
            if (r_vld_pipe[RD_LAT])
                r_vga_data <= i_mem_rdata;
        end
    end

    assign o_mem_re    = r_mem_re;
    assign o_mem_we    = r_mem_we;
    assign o_wr_ack    = r_wr_ack;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_vga_valid = r_vga_valid;
    assign o_vga_data  = r_vga_data;

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_reads;
    logic [15:0] r_stat_wait;

    // Saturating counters: read cycles issued, cycles the host spent waiting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat_reads <= 16'd0;
            r_stat_wait  <= 16'd0;
        end else begin
            if (r_mem_re && (r_stat_reads != 16'hFFFF))
                r_stat_reads <= r_stat_reads + 16'd1;
            if (i_wr_req && !r_wr_ack && (r_stat_wait != 16'hFFFF))
                r_stat_wait <= r_stat_wait + 16'd1;
        end
    end

    assign o_stat_vga_reads = r_stat_reads;
    assign o_stat_host_wait = r_stat_wait;
`endif

endmodule
